// File: rtl/cordic_nco.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_nco
//  Description : Phase-accumulator NCO front/back end for a first-quadrant
//                CORDIC. Folds the accumulator phase into a first-quadrant
//                angle code. A quadrant tag travels alongside each sample so
//                that the full-circle cos/sin signs can be restored when the
//                CORDIC result returns.
//  Revision    : 1.0  initial release
// ============================================================================
module cordic_nco #(
    parameter int D_WIDTH    = 7,
    parameter int PHASE_W    = 16,
    parameter int CORDIC_LAT = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [PHASE_W-1:0]      freq_word,
    input  logic                    phase_load,
    input  logic [PHASE_W-1:0]      phase_init,
    output logic [D_WIDTH-2:0]      z_tgt,
    output logic                    z_vld,
    input  logic signed [D_WIDTH:0] x_in,
    input  logic signed [D_WIDTH:0] y_in,
    output logic signed [D_WIDTH:0] cos_out,
    output logic signed [D_WIDTH:0] sin_out,
    output logic                    out_vld
);

    localparam logic signed [D_WIDTH:0] c_MIN_NEG = {1'b1, {D_WIDTH{1'b0}}};
    localparam logic signed [D_WIDTH:0] c_MAX_POS = {1'b0, {D_WIDTH{1'b1}}};

    // Phase accumulator and folded-angle stage
    logic [PHASE_W-1:0]      acc_q,   acc_d;
    logic [D_WIDTH-2:0]      z_tgt_q, z_tgt_d;
    logic                    z_vld_q, z_vld_d;
    logic [1:0]              quad_q,  quad_d;

    // Quadrant tag pipeline matching the CORDIC latency
    logic [CORDIC_LAT-1:0]   tag_vld_q;
    logic [1:0]              tag_quad_q [CORDIC_LAT];

    // Sign-restored output stage
    logic signed [D_WIDTH:0] cos_q, cos_d;
    logic signed [D_WIDTH:0] sin_q, sin_d;
    logic                    out_vld_q, out_vld_d;

    logic [1:0]              w_quad;
    logic [D_WIDTH-2:0]      w_frac;
    logic                    w_exit_vld;
    logic [1:0]              w_exit_quad;

    // Negation that clamps the most negative code to the most positive one
    function automatic logic signed [D_WIDTH:0] neg_sat(input logic signed [D_WIDTH:0] v);
        if (v == c_MIN_NEG) begin
            return c_MAX_POS;
        end
        return -v;
    endfunction

    assign w_quad      = acc_q[PHASE_W-1 -: 2];
    assign w_frac      = acc_q[PHASE_W-3 -: D_WIDTH-1];
    assign w_exit_vld  = tag_vld_q[CORDIC_LAT-1];
    assign w_exit_quad = tag_quad_q[CORDIC_LAT-1];

    // Accumulator update and quadrant folding; load wins and emits no sample
    always_comb begin
        acc_d   = acc_q;
        z_tgt_d = z_tgt_q;
        z_vld_d = 1'b0;
        quad_d  = quad_q;
        if (phase_load) begin
            acc_d = phase_init;
        end else if (en) begin
            acc_d   = acc_q + freq_word;
            z_vld_d = 1'b1;
            quad_d  = w_quad;
            // Odd quadrants run backwards through the first-quadrant table
            z_tgt_d = w_quad[0] ? ~w_frac : w_frac;
        end
    end

    // Restore full-circle signs when a valid tag exits with its CORDIC result
    always_comb begin
        cos_d     = cos_q;
        sin_d     = sin_q;
        out_vld_d = w_exit_vld;
        if (w_exit_vld) begin
            case (w_exit_quad)
                2'd0: begin cos_d = x_in;          sin_d = y_in;          end
                2'd1: begin cos_d = neg_sat(x_in); sin_d = y_in;          end
                2'd2: begin cos_d = neg_sat(x_in); sin_d = neg_sat(y_in); end
                default: begin cos_d = x_in;       sin_d = neg_sat(y_in); end
            endcase
        end
    end

    // Front-end state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            z_tgt_q <= '0;
            z_vld_q <= 1'b0;
            quad_q  <= 2'd0;
        end else begin
            acc_q   <= acc_d;
            z_tgt_q <= z_tgt_d;
            z_vld_q <= z_vld_d;
            quad_q  <= quad_d;
        end
    end

    // Tag shift register; never flushed except by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            for (int i = 0; i < CORDIC_LAT; i++) begin
                tag_quad_q[i] <= 2'd0;
            end
        end else begin
            tag_vld_q[0]  <= z_vld_q;
            tag_quad_q[0] <= quad_q;
            for (int i = 1; i < CORDIC_LAT; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_quad_q[i] <= tag_quad_q[i-1];
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cos_q     <= '0;
            sin_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            cos_q     <= cos_d;
            sin_q     <= sin_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign z_tgt   = z_tgt_q;
    assign z_vld   = z_vld_q;
    assign cos_out = cos_q;
    assign sin_out = sin_q;
    assign out_vld = out_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_nco.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_nco
//  Description : Scoreboard bench for cordic_nco with a behavioural CORDIC
//                stand-in (fixed latency, programmable x/y response).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cordic_nco;

    localparam int LAT = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              phase_load = 1'b0;
    logic [15:0]       freq_word = 16'h0000;
    logic [15:0]       phase_init = 16'h0000;
    logic [5:0]        z_tgt;
    logic              z_vld;
    logic signed [7:0] x_in, y_in, cos_out, sin_out;
    logic              out_vld;

    cordic_nco #(.D_WIDTH(7), .PHASE_W(16), .CORDIC_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .freq_word(freq_word),
        .phase_load(phase_load), .phase_init(phase_init),
        .z_tgt(z_tgt), .z_vld(z_vld), .x_in(x_in), .y_in(y_in),
        .cos_out(cos_out), .sin_out(sin_out), .out_vld(out_vld)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- CORDIC stand-in ----------------
    bit                ov_on = 1'b0;
    logic signed [7:0] ovx = 8'sd0, ovy = 8'sd0;
    logic signed [7:0] px [LAT];
    logic signed [7:0] py [LAT];

    function automatic logic signed [7:0] mx(input logic [5:0] z);
        if (ov_on) return ovx;
        return $signed({2'b00, z});
    endfunction

    function automatic logic signed [7:0] my(input logic [5:0] z);
        if (ov_on) return ovy;
        return 8'sd32 - $signed({2'b00, z});
    endfunction

    always @(posedge clk) begin
        px[0] <= mx(z_tgt);
        py[0] <= my(z_tgt);
        for (int i = 1; i < LAT; i++) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
        end
    end
    assign x_in = px[LAT-1];
    assign y_in = py[LAT-1];

    // ---------------- scoreboard ----------------
    typedef struct { logic [5:0] z; int cyc; } zexp_t;
    typedef struct { logic signed [7:0] c; logic signed [7:0] s; int cyc; } oexp_t;
    zexp_t zq [$];
    oexp_t oq [$];
    logic [15:0] macc = 16'h0000;

    function automatic logic signed [7:0] nsat(input logic signed [7:0] v);
        if (v == -8'sd128) return 8'sd127;
        return -v;
    endfunction

    // Drive one cycle of stimulus at a falling edge; hand=1 uses the given
    // expected values, otherwise the reference phase model derives them.
    task automatic issue(input logic e, input logic ld, input logic [15:0] init,
                         input bit hand, input logic [5:0] hz,
                         input logic signed [7:0] hc, input logic signed [7:0] hs);
        logic [1:0]        q;
        logic [5:0]        r, z;
        logic signed [7:0] x, y, c, s;
        en = e; phase_load = ld; phase_init = init;
        if (ld) begin
            macc = init;
        end else if (e) begin
            q = macc[15:14];
            r = macc[13:8];
            z = (q == 2'd1 || q == 2'd3) ? ~r : r;
            x = mx(z);
            y = my(z);
            case (q)
                2'd0: begin c = x;       s = y;       end
                2'd1: begin c = nsat(x); s = y;       end
                2'd2: begin c = nsat(x); s = nsat(y); end
                default: begin c = x;    s = nsat(y); end
            endcase
            if (hand) begin z = hz; c = hc; s = hs; end
            zq.push_back('{z, cyc + 1});
            oq.push_back('{c, s, cyc + LAT + 2});
            macc = macc + freq_word;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 16'h0, 1'b0, 6'd0, 8'sd0, 8'sd0);
    endtask

    task automatic drain();
        int n = 0;
        en = 1'b0; phase_load = 1'b0;
        while ((zq.size() != 0 || oq.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (zq.size() != 0 || oq.size() != 0) begin
            chk("drain_timeout", zq.size() + oq.size(), 0);
            zq.delete();
            oq.delete();
        end
    endtask

    // Monitor: compare every presented output against the scoreboard
    always @(negedge clk) begin
        zexp_t ze;
        oexp_t oe;
        if (rst_n) begin
            if (z_vld) begin
                if (zq.size() == 0) begin
                    chk("z_unexpected", 1, 0);
                end else begin
                    ze = zq.pop_front();
                    chk("z_tgt", int'(z_tgt), int'(ze.z));
                    chk("z_cycle", cyc, ze.cyc);
                end
            end
            if (out_vld) begin
                if (oq.size() == 0) begin
                    chk("out_unexpected", 1, 0);
                end else begin
                    oe = oq.pop_front();
                    chk("cos_out", int'(cos_out), int'(oe.c));
                    chk("sin_out", int'(sin_out), int'(oe.s));
                    chk("out_cycle", cyc, oe.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with enable active
        en = 1'b1; freq_word = 16'h0100;
        #23;
        chk("rst_z_tgt", int'(z_tgt), 0);
        chk("rst_z_vld", int'(z_vld), 0);
        chk("rst_cos", int'(cos_out), 0);
        chk("rst_sin", int'(sin_out), 0);
        chk("rst_out_vld", int'(out_vld), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_z_vld", int'(z_vld), 0);
        chk("rst_hold_out_vld", int'(out_vld), 0);
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b1;
        macc = 16'h0000;
        @(negedge clk);

        // Full sweep across the accumulator wrap
        for (int k = 0; k < 260; k++) issue(1'b1, 1'b0, 16'h0, 1'b0, 6'd0, 8'sd0, 8'sd0);
        drain();

        // Load with enable in the same cycle: no sample, then q2 z=0
        ov_on = 1'b1; ovx = 8'sd64; ovy = 8'sd0;
        issue(1'b1, 1'b1, 16'h8000, 1'b0, 6'd0, 8'sd0, 8'sd0);
        chk("load_no_sample", int'(z_vld), 0);
        issue(1'b1, 1'b0, 16'h0, 1'b1, 6'd0, -8'sd64, 8'sd0);
        drain();

        // q1 and q3 sign restoration
        ovx = 8'sd10; ovy = 8'sd50;
        issue(1'b0, 1'b1, 16'h4000, 1'b0, 6'd0, 8'sd0, 8'sd0);
        issue(1'b1, 1'b0, 16'h0, 1'b1, 6'd63, -8'sd10, 8'sd50);
        issue(1'b0, 1'b1, 16'hC000, 1'b0, 6'd0, 8'sd0, 8'sd0);
        issue(1'b1, 1'b0, 16'h0, 1'b1, 6'd63, 8'sd10, -8'sd50);
        drain();

        // Saturating negation on both rails
        ovx = -8'sd128; ovy = 8'sd0;
        issue(1'b0, 1'b1, 16'h8000, 1'b0, 6'd0, 8'sd0, 8'sd0);
        issue(1'b1, 1'b0, 16'h0, 1'b1, 6'd0, 8'sd127, 8'sd0);
        drain();
        ovx = 8'sd5; ovy = -8'sd128;
        issue(1'b0, 1'b1, 16'hC000, 1'b0, 6'd0, 8'sd0, 8'sd0);
        issue(1'b1, 1'b0, 16'h0, 1'b1, 6'd63, 8'sd5, 8'sd127);
        drain();

        // Enable bubbles 1,0,1,1,0
        ov_on = 1'b0;
        issue(1'b0, 1'b1, 16'h0000, 1'b0, 6'd0, 8'sd0, 8'sd0);
        issue(1'b1, 1'b0, 16'h0, 1'b1, 6'd0, 8'sd0, 8'sd32);
        idle();
        issue(1'b1, 1'b0, 16'h0, 1'b1, 6'd1, 8'sd1, 8'sd31);
        issue(1'b1, 1'b0, 16'h0, 1'b1, 6'd2, 8'sd2, 8'sd30);
        idle();
        drain();

        // Mid-run reset with six samples in flight
        for (int k = 0; k < 6; k++) issue(1'b1, 1'b0, 16'h0, 1'b0, 6'd0, 8'sd0, 8'sd0);
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_vld", int'(out_vld), 0);
        chk("midrst_z_vld", int'(z_vld), 0);
        chk("midrst_cos", int'(cos_out), 0);
        zq.delete();
        oq.delete();
        macc = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) idle();
        issue(1'b1, 1'b0, 16'h0, 1'b1, 6'd0, 8'sd0, 8'sd32);
        drain();

        chk("final_zq_empty", zq.size(), 0);
        chk("final_oq_empty", oq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
